// File: rtl/audio_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// audio_fetch_sequencer
//
// Playback sequencer for the audio byte-output path. Reads 32-bit sample words
// from flash over an Avalon-MM style read port, then presents one byte per
// sample_tick. Forward play walks lanes [7:0] -> [31:24]; backward play walks
// [31:24] -> [7:0]. Owns the word address, play/pause, direction and restart.
//
// Ports
//   clk, reset_n         single clock, asynchronous active-low reset
//   sample_tick          one-clk pulse at the sample rate (synchronous to clk)
//   play                 1 = play, 0 = pause
//   direction            1 = forward, 0 = backward
//   restart              one-clk pulse: jump to song start (fwd) / end (bwd)
//   flash_waitrequest    slave stall
//   flash_readdata       read data
//   flash_readdatavalid  read data strobe
//   flash_read           read request
//   flash_address        word address of the request
//   audio_byte           current sample
//   byte_select          lane of the next byte to be played
//   sample_valid         one-clk pulse coincident with each audio_byte update
//   underrun             sticky: a tick found no word ready; cleared by restart
//   fsm_state            debug view of the sequencer state
//
// Read handshake: flash_read and flash_address are held stable while
// flash_waitrequest is high; a command is accepted on a clock edge where
// flash_read=1 and flash_waitrequest=0. Exactly one readdatavalid strobe
// answers each accepted command, and only one command is ever outstanding.
// -----------------------------------------------------------------------------
module audio_fetch_sequencer #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              direction,
    input  logic              restart,
    input  logic              flash_waitrequest,
    input  logic [31:0]       flash_readdata,
    input  logic              flash_readdatavalid,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    output logic [7:0]        audio_byte,
    output logic [1:0]        byte_select,
    output logic              sample_valid,
    output logic              underrun,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_DATA = 2'd1,
        PLAY      = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [31:0]       word_buf;
    logic              word_ready;
    logic              play_dir;      // walk direction of the word being played
    logic              retarget;      // restart arrived while a request was stalled
    logic [ADDR_W-1:0] retarget_addr;

    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [1:0]        start_idx;
    logic [7:0]        cur_byte;
    logic              last_byte;
    logic              tick_play;
    logic              accept;

    assign fsm_state = state;

    always_comb begin
        restart_addr = direction ? START_ADDR : END_ADDR;
        start_idx    = direction ? 2'd0 : 2'd3;
        last_byte    = play_dir ? (byte_select == 2'd3) : (byte_select == 2'd0);
        tick_play    = sample_tick && play;
        accept       = flash_read && !flash_waitrequest;

        cur_byte = word_buf[7:0];
        case (byte_select)
            2'd1:    cur_byte = word_buf[15:8];
            2'd2:    cur_byte = word_buf[23:16];
            2'd3:    cur_byte = word_buf[31:24];
            default: cur_byte = word_buf[7:0];
        endcase

        // The step at a word boundary follows the direction input, so a
        // direction change lands exactly on the boundary.
        if (direction) begin
            next_addr = (flash_address == END_ADDR) ? START_ADDR : flash_address + ADDR_ONE;
        end else begin
            next_addr = (flash_address == START_ADDR) ? END_ADDR : flash_address - ADDR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            flash_read    <= 1'b0;
            flash_address <= START_ADDR;
            audio_byte    <= 8'h00;
            byte_select   <= 2'd0;
            sample_valid  <= 1'b0;
            underrun      <= 1'b0;
            word_buf      <= 32'h0;
            word_ready    <= 1'b0;
            play_dir      <= 1'b1;
            retarget      <= 1'b0;
            retarget_addr <= START_ADDR;
        end else begin
            sample_valid <= 1'b0;

            if (restart) begin
                // Restart outranks a coincident tick: nothing is emitted.
                byte_select <= start_idx;
                play_dir    <= direction;
                word_ready  <= 1'b0;
                underrun    <= 1'b0;
                case (state)
                    FETCH: begin
                        if (flash_read && flash_waitrequest) begin
                            // The stalled command must stay stable; it will be
                            // accepted at the old address and its data dropped.
                            retarget      <= 1'b1;
                            retarget_addr <= restart_addr;
                        end else if (accept) begin
                            // Accepted on this edge: its data is still coming.
                            flash_read    <= 1'b0;
                            flash_address <= restart_addr;
                            retarget      <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            flash_address <= restart_addr;
                        end
                    end
                    WAIT_DATA, DRAIN: begin
                        flash_address <= restart_addr;
                        state         <= flash_readdatavalid ? FETCH : DRAIN;
                    end
                    default: begin
                        flash_address <= restart_addr;
                        state         <= FETCH;
                    end
                endcase
            end else begin
                if (tick_play && !word_ready) begin
                    underrun <= 1'b1;
                end

                case (state)
                    FETCH: begin
                        if (!flash_read) begin
                            flash_read <= 1'b1;
                        end else if (!flash_waitrequest) begin
                            flash_read <= 1'b0;
                            if (retarget) begin
                                flash_address <= retarget_addr;
                                retarget      <= 1'b0;
                                state         <= DRAIN;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                    WAIT_DATA: begin
                        if (flash_readdatavalid) begin
                            word_buf   <= flash_readdata;
                            word_ready <= 1'b1;
                            state      <= PLAY;
                        end
                    end
                    DRAIN: begin
                        if (flash_readdatavalid) begin
                            state <= FETCH;
                        end
                    end
                    default: begin
                        if (tick_play && word_ready) begin
                            audio_byte   <= cur_byte;
                            sample_valid <= 1'b1;
                            if (last_byte) begin
                                word_ready    <= 1'b0;
                                byte_select   <= start_idx;
                                play_dir      <= direction;
                                flash_address <= next_addr;
                                state         <= FETCH;
                            end else begin
                                byte_select <= play_dir ? byte_select + 2'd1
                                                        : byte_select - 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for audio_fetch_sequencer. A small flash slave (programmable stall and
// read latency) answers the read port from a 4-word song (END_ADDR = 3). The
// reference model treats the song as a byte stream: words taken in address
// order with wrap, each split into lanes in the walk direction.
// -----------------------------------------------------------------------------
module tb_audio_fetch_sequencer;

    localparam int          ADDR_W = 23;
    localparam logic [22:0] START  = 23'd0;
    localparam logic [22:0] LAST   = 23'd3;

    logic              clk;
    logic              reset_n;
    logic              sample_tick;
    logic              play;
    logic              direction;
    logic              restart;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic [7:0]        audio_byte;
    logic [1:0]        byte_select;
    logic              sample_valid;
    logic              underrun;
    logic [1:0]        fsm_state;

    audio_fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START),
        .END_ADDR  (LAST)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sample_tick        (sample_tick),
        .play               (play),
        .direction          (direction),
        .restart            (restart),
        .flash_waitrequest  (flash_waitrequest),
        .flash_readdata     (flash_readdata),
        .flash_readdatavalid(flash_readdatavalid),
        .flash_read         (flash_read),
        .flash_address      (flash_address),
        .audio_byte         (audio_byte),
        .byte_select        (byte_select),
        .sample_valid       (sample_valid),
        .underrun           (underrun),
        .fsm_state          (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int sv_count = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // ---------------- flash contents and slave ----------------
    logic [31:0] mem [0:3];
    int          ws_cfg;
    int          lat_cfg;
    int          stall_left;
    bit          in_cmd;
    bit          resp_pending;
    int          resp_wait;
    logic [22:0] resp_addr;
    logic [22:0] held_addr;
    bit          stalled_prev;

    initial begin
        flash_waitrequest   = 1'b0;
        flash_readdata      = 32'h0;
        flash_readdatavalid = 1'b0;
        in_cmd = 0; resp_pending = 0; stalled_prev = 0; stall_left = 0; resp_wait = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                in_cmd = 0; resp_pending = 0; stalled_prev = 0;
                flash_waitrequest   = 1'b0;
                flash_readdatavalid = 1'b0;
            end else begin
                #1;
                flash_readdatavalid = 1'b0;
                if (resp_pending) begin
                    if (resp_wait == 0) begin
                        flash_readdatavalid = 1'b1;
                        flash_readdata      = mem[resp_addr[1:0]];
                        resp_pending        = 0;
                    end else begin
                        resp_wait--;
                    end
                end
                if (stalled_prev) begin
                    check("stall_read_held", {31'd0, flash_read}, 32'd1);
                    check("stall_addr_held", {9'd0, flash_address}, {9'd0, held_addr});
                end
                stalled_prev = 0;
                if (flash_read) begin
                    if (!in_cmd) begin
                        in_cmd     = 1;
                        stall_left = ws_cfg;
                    end
                    if (stall_left > 0) begin
                        flash_waitrequest = 1'b1;
                        stall_left--;
                        stalled_prev = 1;
                        held_addr    = flash_address;
                    end else begin
                        flash_waitrequest = 1'b0;
                        in_cmd            = 0;
                        check("one_outstanding", {31'd0, resp_pending}, 32'd0);
                        resp_pending = 1;
                        resp_wait    = lat_cfg;
                        resp_addr    = flash_address;
                    end
                end else begin
                    flash_waitrequest = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_q[$];
    logic [22:0] m_addr;
    int          m_idx;
    logic        m_dir;
    logic [7:0]  last_byte;

    function automatic logic [22:0] next_addr(input logic [22:0] a, input logic fwd);
        if (fwd) return (a == LAST) ? START : a + 23'd1;
        return (a == START) ? LAST : a - 23'd1;
    endfunction

    function automatic logic [7:0] lane_of(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (8 * k);
        return s[7:0];
    endfunction

    function automatic logic [31:0] exp_sel();
        return m_dir ? m_idx : 3 - m_idx;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_addr = START; m_idx = 0; m_dir = 1'b1; last_byte = 8'h00;
    endtask

    task automatic model_restart();
        exp_q.delete();
        m_addr = direction ? START : LAST; m_idx = 0; m_dir = direction;
    endtask

    task automatic model_emit();
        logic [7:0] b;
        b = lane_of(mem[m_addr[1:0]], m_dir ? m_idx : 3 - m_idx);
        exp_q.push_back(b);
        last_byte = b;
        m_idx++;
        if (m_idx == 4) begin
            m_idx  = 0;
            m_addr = next_addr(m_addr, direction);
            m_dir  = direction;
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n && sample_valid) begin
            logic [7:0] eb;
            sv_count++;
            check("sample_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                eb = exp_q.pop_front();
                check("audio_byte", {24'd0, audio_byte}, {24'd0, eb});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit expect_sample);
        sample_tick = 1'b1;
        if (expect_sample) model_emit();
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        model_restart();
        step(1);
        restart = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int svc;
        int n;
        reset_n = 1'b1; sample_tick = 1'b0; play = 1'b1; direction = 1'b1; restart = 1'b0;
        ws_cfg = 0; lat_cfg = 0;
        mem[0] = 32'h44332211; mem[1] = 32'h88776655;
        mem[2] = 32'h1234ABCD; mem[3] = 32'hDDCCBBAA;
        model_reset();
        #2 reset_n = 1'b0;
        step(2);
        check("rst_flash_address", {9'd0, flash_address}, 32'd0);
        check("rst_flash_read", {31'd0, flash_read}, 32'd0);
        check("rst_audio_byte", {24'd0, audio_byte}, 32'd0);
        check("rst_byte_select", {30'd0, byte_select}, 32'd0);
        check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        reset_n = 1'b1;

        // Forward play through words 0 and 1.
        step(12);
        check("fwd_addr_initial", {9'd0, flash_address}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            step(7);
            if (i == 3) check("fwd_addr_word1", {9'd0, flash_address}, 32'd1);
        end
        check("fwd_addr_word2", {9'd0, flash_address}, 32'd2);
        check("fwd_underrun", {31'd0, underrun}, 32'd0);
        check("fwd_all_samples", exp_q.size(), 32'd0);
        check("fwd_byte_select", {30'd0, byte_select}, exp_sel());

        // Backward from END_ADDR, then next word at END_ADDR-1.
        direction = 1'b0;
        pulse_restart();
        step(10);
        check("bwd_addr_start", {9'd0, flash_address}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            step(7);
        end
        check("bwd_addr_next", {9'd0, flash_address}, 32'd2);
        check("bwd_byte_select", {30'd0, byte_select}, exp_sel());

        // Direction flips mid-word: takes effect at the boundary, 3 wraps to 0.
        pulse_restart();
        step(10);
        tick(1);
        step(7);
        direction = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            step(7);
        end
        check("fwd_wrap_addr", {9'd0, flash_address}, 32'd0);
        check("dirchg_byte_select", {30'd0, byte_select}, exp_sel());
        for (int i = 0; i < 4; i++) begin
            tick(1);
            step(7);
        end
        check("dirchg_addr_after", {9'd0, flash_address}, 32'd1);
        check("dirchg_all_samples", exp_q.size(), 32'd0);

        // Stall of 5 clocks, data 10 clocks after acceptance, ticks every 4.
        ws_cfg = 5; lat_cfg = 10;
        pulse_restart();
        for (int i = 0; i < 4; i++) begin
            step(3);
            if (i == 0) begin
                check("stall_flash_read", {31'd0, flash_read}, 32'd1);
                check("stall_flash_address", {9'd0, flash_address}, 32'd0);
            end
            tick(0);
        end
        check("stall_underrun", {31'd0, underrun}, 32'd1);
        check("stall_audio_held", {24'd0, audio_byte}, {24'd0, last_byte});
        step(8);
        tick(1);
        step(3);
        check("stall_underrun_sticky", {31'd0, underrun}, 32'd1);
        check("stall_all_samples", exp_q.size(), 32'd0);
        ws_cfg = 0; lat_cfg = 0;

        // Pause mid-word after the second byte.
        pulse_restart();
        step(10);
        check("restart_clears_underrun", {31'd0, underrun}, 32'd0);
        tick(1); step(5);
        tick(1); step(5);
        play = 1'b0;
        svc  = sv_count;
        for (int i = 0; i < 6; i++) begin
            tick(0);
            step(3);
        end
        check("pause_no_samples", sv_count, svc);
        check("pause_audio_held", {24'd0, audio_byte}, 32'h22);
        check("pause_byte_select", {30'd0, byte_select}, exp_sel());
        check("pause_no_underrun", {31'd0, underrun}, 32'd0);
        play = 1'b1;
        tick(1); step(5);
        check("resume_audio", {24'd0, audio_byte}, 32'h33);
        // Fetch triggered by the word's last byte completes while paused.
        tick(1);
        play = 1'b0;
        step(10);
        play = 1'b1;
        tick(1); step(5);
        check("pause_fetch_no_underrun", {31'd0, underrun}, 32'd0);

        // Restart while a slow read is outstanding.
        tick(1); step(5);
        tick(1); step(5);
        lat_cfg = 12;
        tick(1);
        step(4);
        tick(0);
        check("wait_underrun", {31'd0, underrun}, 32'd1);
        pulse_restart();
        lat_cfg = 0;
        check("drain_underrun_cleared", {31'd0, underrun}, 32'd0);
        check("drain_restart_addr", {9'd0, flash_address}, 32'd0);
        step(20);
        tick(1);
        step(5);
        check("drain_all_samples", exp_q.size(), 32'd0);

        // Asynchronous reset between clock edges while playing.
        step(3);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("areset_flash_address", {9'd0, flash_address}, 32'd0);
        check("areset_flash_read", {31'd0, flash_read}, 32'd0);
        check("areset_audio_byte", {24'd0, audio_byte}, 32'd0);
        check("areset_byte_select", {30'd0, byte_select}, 32'd0);
        check("areset_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("areset_underrun", {31'd0, underrun}, 32'd0);
        #2 reset_n = 1'b1;
        step(1);
        check("post_reset_read", {31'd0, flash_read}, 32'd1);
        check("post_reset_addr", {9'd0, flash_address}, 32'd0);
        step(10);
        tick(1);
        step(5);
        check("post_reset_samples", exp_q.size(), 32'd0);

        // Randomized segments: random song, timing and direction flips.
        for (int seg = 0; seg < 6; seg++) begin
            for (int k = 0; k < 4; k++) mem[k] = $urandom;
            ws_cfg    = $urandom_range(0, 3);
            lat_cfg   = $urandom_range(0, 4);
            direction = 1'($urandom_range(0, 1));
            pulse_restart();
            step(30);
            n = $urandom_range(6, 14);
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 3) == 0) direction = ~direction;
                tick(1);
                step(ws_cfg + lat_cfg + 6 + $urandom_range(0, 2));
            end
            check("rand_all_samples", exp_q.size(), 32'd0);
            check("rand_no_underrun", {31'd0, underrun}, 32'd0);
            check("rand_byte_select", {30'd0, byte_select}, exp_sel());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
